// File: rtl/gate_acc.sv
// rtl/gate_acc.sv - registered bitwise gate with optional DEPTH-beat fold; optional y_par via GATE_ACC_PARITY_EN
module gate_acc #(
  parameter int W = 8,
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  b,
  input  logic [1:0]    op,
  input  logic          mode,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  y,
  output logic [CW-1:0] beat_cnt
`ifdef GATE_ACC_PARITY_EN
  ,
  output logic          y_par
`endif
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ACC  = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  logic [1:0]   state;
  logic [1:0]   op_l;
  logic         mode_l;
  logic [W-1:0] acc;

  logic         accept;
  logic         produce;
  logic         start;
  logic [W-1:0] f_new;
  logic [W-1:0] f_grp;
  logic [W-1:0] fold;

  function automatic logic [W-1:0] apply_op(input logic [1:0] o,
                                            input logic [W-1:0] x,
                                            input logic [W-1:0] z);
    logic [W-1:0] r;
    r = '0;
    case (o)
      2'b00:   r = x & z;
      2'b01:   r = x | z;
      2'b10:   r = x ^ z;
      default: r = ~(x ^ z);
    endcase
    return r;
  endfunction

  // Handshake decode; a held result may drain and make room for a new beat in one cycle
  always_comb begin
    in_ready = (state != HOLD) || out_ready;
    accept   = in_valid && in_ready;
    produce  = out_valid && out_ready;
    // In HOLD an accept implies the pending result is leaving this same cycle
    start    = accept && (state != ACC);
    f_new    = apply_op(op, a, b);
    // Beats inside a group use the op latched on its first beat, not the live op input
    f_grp    = apply_op(op_l, a, b);
    fold     = apply_op(op_l, acc, f_grp);
  end

  // Group sequencing, fold accumulator and the registered result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      op_l      <= 2'b00;
      mode_l    <= 1'b0;
      acc       <= '0;
      y         <= '0;
      out_valid <= 1'b0;
      beat_cnt  <= '0;
    end else if (start) begin
      op_l   <= op;
      mode_l <= mode;
      if (!mode) begin
        y         <= f_new;
        out_valid <= 1'b1;
        beat_cnt  <= '0;
        state     <= HOLD;
      end else begin
        acc       <= f_new;
        out_valid <= 1'b0;
        beat_cnt  <= CW'(1);
        state     <= ACC;
      end
    end else if (state == ACC && mode_l && accept) begin
      if (beat_cnt == CW'(DEPTH - 1)) begin
        y         <= fold;
        out_valid <= 1'b1;
        beat_cnt  <= '0;
        state     <= HOLD;
      end else begin
        acc      <= fold;
        beat_cnt <= beat_cnt + CW'(1);
      end
    end else if (state == HOLD && produce) begin
      out_valid <= 1'b0;
      state     <= IDLE;
    end
  end

`ifdef GATE_ACC_PARITY_EN
  // Parity tracks every value loaded into y, so it is stable whenever y is
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_par <= 1'b0;
    end else if (start && !mode) begin
      y_par <= ^f_new;
    end else if (state == ACC && mode_l && accept && beat_cnt == CW'(DEPTH - 1)) begin
      y_par <= ^fold;
    end
  end
`endif

endmodule

// File: tb/tb_gate_acc.sv
// tb/tb_gate_acc.sv - self-checking bench for gate_acc (scoreboard model plus directed literals)
module tb_gate_acc;
  localparam int W = 8;
  localparam int DEPTH = 4;
  localparam int CW = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic [1:0]    op;
  logic          mode;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  y;
  logic [CW-1:0] beat_cnt;
`ifdef GATE_ACC_PARITY_EN
  logic          y_par;
`endif

  int checks = 0;
  int errors = 0;

  gate_acc #(.W(W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .mode(mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .beat_cnt(beat_cnt)
`ifdef GATE_ACC_PARITY_EN
    , .y_par(y_par)
`endif
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endfunction

  function automatic logic [W-1:0] gate(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] z);
    case (o)
      2'b00:   return x & z;
      2'b01:   return x | z;
      2'b10:   return x ^ z;
      default: return ~(x ^ z);
    endcase
  endfunction

  // Behavioural reference: a result is pending or not, and a group is a list of gated beats reduced at the end
  logic [W-1:0] m_y;
  bit           m_valid;
  int           m_cnt;
  logic [1:0]   m_op;
  bit           m_mode;
  logic [W-1:0] m_items[$];
  bit           m_take;
  logic [W-1:0] m_r;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_y = '0; m_valid = 0; m_cnt = 0; m_op = 2'b00; m_mode = 0;
      m_items.delete();
    end else begin
      m_take = in_valid && (!m_valid || out_ready);
      if (m_valid && out_ready) m_valid = 0;
      if (m_take) begin
        if (m_cnt == 0) begin m_op = op; m_mode = mode; end
        if (!m_mode) begin
          m_y = gate(op, a, b);
          m_valid = 1;
        end else begin
          m_items.push_back(gate(m_op, a, b));
          m_cnt++;
          if (m_cnt == DEPTH) begin
            m_r = m_items[0];
            for (int i = 1; i < DEPTH; i++) m_r = gate(m_op, m_r, m_items[i]);
            m_y = m_r;
            m_valid = 1;
            m_cnt = 0;
            m_items.delete();
          end
        end
      end
    end
  end

  // Every cycle out of reset the DUT must match the reference
  always @(negedge clk) begin
    if (rst_n) begin
      chk("out_valid", 32'(out_valid), 32'(m_valid));
      chk("in_ready", 32'(in_ready), 32'(!m_valid || out_ready));
      chk("y", 32'(y), 32'(m_y));
      chk("beat_cnt", 32'(beat_cnt), 32'(m_cnt));
`ifdef GATE_ACC_PARITY_EN
      chk("y_par", 32'(y_par), 32'(^m_y));
`endif
    end
  end

  // Present one beat and hold it until accepted; returns #1 after the accepting edge
  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic [1:0] top, input logic tmode);
    bit got;
    got = 0;
    a = ta; b = tb; op = top; mode = tmode; in_valid = 1'b1;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (in_ready) got = 1;
      @(posedge clk);
      #1;
    end
    if (!got) begin
      errors++;
      $display("FAIL send_timeout got=0 expected=1 at %0t", $time);
    end
    in_valid = 1'b0;
  endtask

  logic [7:0] sweep_exp [4];

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; op = 2'b00; mode = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_y", 32'(y), 32'h00);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;

    // Reset mid-accumulation discards the partial group
    send(8'h01, 8'h00, 2'b01, 1'b1);
    send(8'h02, 8'h00, 2'b01, 1'b1);
    chk("mid_beat_cnt", 32'(beat_cnt), 32'd2);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("rst2_out_valid", 32'(out_valid), 32'd0);
    chk("rst2_y", 32'(y), 32'h00);
    chk("rst2_beat_cnt", 32'(beat_cnt), 32'd0);
    chk("rst2_in_ready", 32'(in_ready), 32'd1);
    repeat (5) @(posedge clk);
    #1;
    chk("rst2_no_result", 32'(out_valid), 32'd0);

    // Single-mode truth sweep, back to back
    sweep_exp[0] = 8'h30; sweep_exp[1] = 8'hFC; sweep_exp[2] = 8'hCC; sweep_exp[3] = 8'h33;
    for (int k = 0; k < 4; k++) begin
      send(8'hF0, 8'h3C, 2'(k), 1'b0);
      chk("sweep_valid", 32'(out_valid), 32'd1);
      chk("sweep_y", 32'(y), 32'(sweep_exp[k]));
    end
    @(posedge clk); #1;

    // Accumulate OR
    for (int k = 0; k < 4; k++) begin
      send(8'(1 << k), 8'h00, 2'b01, 1'b1);
      chk("acc_or_cnt", 32'(beat_cnt), (k == 3) ? 32'd0 : 32'(k + 1));
    end
    chk("acc_or_valid", 32'(out_valid), 32'd1);
    chk("acc_or_y", 32'(y), 32'h0F);
    @(posedge clk); #1;

    // Accumulate XOR with the live op changed after the first beat
    send(8'hFF, 8'h00, 2'b10, 1'b1);
    send(8'h0F, 8'h00, 2'b00, 1'b1);
    send(8'h01, 8'h00, 2'b00, 1'b1);
    send(8'h10, 8'h00, 2'b00, 1'b1);
    chk("acc_xor_y", 32'(y), 32'hE1);
    @(posedge clk); #1;

    // Backpressure, then same-cycle drain and accept
    out_ready = 1'b0;
    send(8'hF0, 8'h3C, 2'b00, 1'b0);
    a = 8'hFF; b = 8'h0F; op = 2'b00; mode = 1'b0; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_y", 32'(y), 32'h30);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    #1 out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_drain_valid", 32'(out_valid), 32'd1);
    chk("bp_drain_y", 32'(y), 32'h0F);
    @(posedge clk); #1;

`ifdef GATE_ACC_PARITY_EN
    send(8'h07, 8'h00, 2'b01, 1'b0);
    chk("par_07", 32'(y_par), 32'd1);
    send(8'h03, 8'h00, 2'b01, 1'b0);
    chk("par_03", 32'(y_par), 32'd0);
    @(posedge clk); #1;
`endif

    // Randomized traffic against the reference, with one reset in the middle
    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      a = 8'($urandom); b = 8'($urandom);
      op = 2'($urandom); mode = 1'($urandom);
      rst_n = !(c == 1500 || c == 1501);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gate_acc.md
Name: gate_acc

Overview:
- Parametrised, registered successor to the team's 2-input combinational gates.
- Applies a selectable bitwise logic op (AND/OR/XOR/XNOR) to two W-bit operands behind a valid/ready handshake.
- Optionally folds DEPTH consecutive results into one reduced word.
- Sits between a stimulus/producer stage and a consumer in the lab datapath; one result beat per handshake on each side.

Parameters:
- W, 8, operand/result width in bits (>=1).
- DEPTH, 4, beats folded per result in accumulate mode (>=2).
- CW, $clog2(DEPTH+1), width of beat_cnt (derived localparam, not overridable).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  producer has a valid operand pair.
- in_ready  out  1  block accepts the pair this cycle.
- a  in  W  operand A.
- b  in  W  operand B.
- op  in  2  00=AND, 01=OR, 10=XOR, 11=XNOR; sampled on the first beat of a group.
- mode  in  1  0=single, 1=accumulate; sampled on the first beat of a group.
- out_valid  out  1  y holds a valid result.
- out_ready  in  1  consumer takes the result.
- y  out  W  registered result.
- beat_cnt  out  CW  beats accepted in the current group.

Behaviour:
- Reset values (async on rst_n low): state=IDLE, out_valid=0, y=0, beat_cnt=0, latched op=00, latched mode=0; in_ready=1 after reset.
- Accept condition is in_valid && in_ready. Produce condition is out_valid && out_ready.
- in_ready = (state != HOLD) || out_ready, which allows a same-cycle drain and accept.
- f(a,b) = a op b, bitwise.
- State machine:
  - IDLE, on accept with mode=0: y<=f; out_valid<=1 next cycle; go to HOLD. Latency is 1 cycle.
  - IDLE, on accept with mode=1: acc<=f; beat_cnt<=1; latch op/mode; go to ACC.
  - ACC, on accept: acc<=acc op_l f, where op_l is the latched op (AND/OR/XOR/XNOR fold, all associative); beat_cnt++.
  - ACC, on the DEPTH-th accept: y<=folded value; out_valid<=1 next cycle; beat_cnt<=0; go to HOLD.
  - ACC, no accept: hold acc and beat_cnt; no timeout.
  - HOLD: y and out_valid stable until the produce condition.
  - HOLD, on produce with no accept: out_valid<=0; go to IDLE.
  - HOLD, on produce with simultaneous accept: process the new beat exactly as from IDLE in the same cycle, giving a back-to-back result every cycle in single mode.
- op/mode changes during ACC are ignored until the next group starts.
- Asserting rst_n low mid-group discards the partial acc and any pending y; nothing is emitted after reset.
- y is never modified while out_valid=1 and out_ready=0.
- All arithmetic is bitwise; there is no carry and no width growth.

Optional Feature:
- Macro GATE_ACC_PARITY_EN.
- Defined: adds output y_par (1 bit) = even parity (^) of the value loaded into y, registered with y. It is 0 on reset and stable while in HOLD.
- Undefined: the port is absent; behaviour is otherwise identical.

Test Plan:
- Reset: hold rst_n=0 mid-accumulation (beat_cnt=2), release -> out_valid=0, y=8'h00, beat_cnt=0, in_ready=1; no spurious result follows.
- Single mode truth sweep, W=8, out_ready=1:
  - a=8'hF0, b=8'h3C -> op 00 gives y=8'h30; 01 gives 8'hFC; 10 gives 8'hCC; 11 gives 8'h33.
  - Each result appears 1 cycle after accept, one per cycle back-to-back.
- Accumulate OR, DEPTH=4, mode=1, op=01, b=0, a=8'h01,8'h02,8'h04,8'h08 -> single result y=8'h0F one cycle after the 4th beat; beat_cnt goes 1,2,3 then 0.
- Accumulate XOR with mid-group op change: op=10 on beat 1 and op=00 on beats 2-4, b=0, a=8'hFF,8'h0F,8'h01,8'h10 -> y=8'hE1 (latched XOR used).
- Backpressure: out_ready=0 for 5 cycles after a result -> y and out_valid stable, in_ready=0, and in_valid beats are not consumed. Raising out_ready with in_valid=1 -> drain and accept happen in the same cycle.
- With GATE_ACC_PARITY_EN: y=8'h07 -> y_par=1; y=8'h03 -> y_par=0.
